mux_nx1_pipe: RTL and testbench
===============================

// Module: mux_nx1_pipe
// PURPOSE
//  Parametrised N-input, W-bit operand select with a registered output stage.
//  Carries a valid/ready handshake and a 2-entry skid buffer, so backpressure
//  never drops a beat or costs throughput.
//  Sits between register-file/forwarding sources and the ALU operand latch.
//  Successor to the fixed 4x1 32-bit combinational select.
// PARAMETERS
//  WIDTH    32                        data width per input
//  NUM_IN   4                         number of inputs, >=2, need not be a power of 2
//  SEL_W    $clog2(NUM_IN)            select width (derived; do not override)
// PORTS
//  clk       in   1               rising-edge clock, single domain
//  reset     in   1               synchronous, active-high reset
//  flush     in   1               synchronous pipeline flush
//  in_data   in   NUM_IN*WIDTH    packed inputs; input i = in_data[i*WIDTH +: WIDTH]
//  sel       in   SEL_W           input select, sampled with in_valid
//  in_valid  in   1               upstream beat present
//  in_ready  out  1               block can accept a beat (registered, = !skid_valid)
//  out_data  out  WIDTH           selected data
//  out_valid out  1               out_data valid
//  out_ready in   1               downstream accepts
//  out_selerr out 1               beat was captured with sel >= NUM_IN (travels with data)
// BEHAVIOUR
//  Clock, reset and flush
//  - One clock: clk. Reset is synchronous and active-high (port reset).
//  - Reset state: out_valid=0, out_data=0, out_selerr=0, skid empty, in_ready=1.
//  - Reset/flush mid-transfer discards every held beat; no partial output.
//  Handshake and select
//  - Accept = in_valid & in_ready. Emit = out_valid & out_ready.
//  - Select: data = in_data[sel] when sel < NUM_IN.
//    Otherwise data = 0 and selerr = 1.
//  - Latency: a beat accepted in cycle t appears on out_data in cycle t+1.
//  States (occupancy): EMPTY(0) / ONE(main reg) / TWO(main + skid).
//  - EMPTY: accept -> ONE.
//  - ONE: accept & !emit -> TWO (beat goes to skid).
//  - ONE: accept & emit -> ONE (main reloads).
//  - ONE: !accept & emit -> EMPTY.
//  - TWO: in_ready=0. Emit -> ONE (skid moves to main, skid cleared).
//  Boundary rules
//  - Simultaneous accept and emit in ONE keeps throughput at 1 beat per cycle.
//  - Outputs stay stable while out_valid & !out_ready (AXI-style hold rule).
//  - flush: next cycle returns to EMPTY and in_ready=1.
//    flush outranks a same-cycle accept (that beat is dropped).
//    out_data holds its last value; only the valid flags clear.
//  - reset outranks flush.
//  - in_valid while in_ready=0 has no effect.
//    Upstream must hold its beat; the block does not check this.
//  - out_data content is don't-care when out_valid=0, except at reset (0).
//  Width rules
//  - No arithmetic.
//  - NUM_IN not a power of 2 leaves unused sel codes; these follow the selerr rule.
// STRUCTURE
//  - Shared package ppu_pkg: occupancy state encoding (EMPTY/ONE/TWO),
//    function clog2_min1 (returns >=1), localparam DATA_W_DEFAULT=32.
//  - One sub-module, skid_buffer_2e #(WIDTH+1): generic 2-entry valid/ready
//    skid buffer carrying {selerr, data}.
//  - Combinational select lives in this top as an indexed part-select.
// TESTING
//  1 Reset: hold reset 2 cycles with in_valid=1
//    -> out_valid=0, out_data=0, in_ready=1 throughout, and 1 cycle after release.
//  2 Stream: NUM_IN=4, inputs 0xA0..0xA3, out_ready=1, sel=0,1,2,3 on consecutive cycles
//    -> out_data 0xA0,0xA1,0xA2,0xA3 on cycles t+1..t+4; no bubbles.
//  3 Backpressure: out_ready=0 and send 2 beats (0x11, 0x22)
//    -> in_ready=0 after the 2nd; out_data holds 0x11.
//    Raise out_ready -> 0x11 then 0x22, in_ready=1 after the first emit.
//  4 Bad select: NUM_IN=3, sel=3, in_data lanes nonzero
//    -> out_data=0, out_selerr=1 next cycle; the following sel=2 beat has selerr=0.
//  5 Flush: state TWO, then flush=1 together with in_valid=1
//    -> next cycle out_valid=0, in_ready=1; the flushed-cycle beat never appears.
//  6 Reset mid-stream: reset asserted while out_valid=1 & out_ready=0
//    -> next cycle out_valid=0, out_data=0, out_selerr=0.
//  Scoreboard: random valid/ready on both sides;
//  in-order, loss-free, duplicate-free delivery.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared definitions for the operand-select pipeline slice.
// Occupancy codes keep bit1 = skid full and bit0 = main full.
package ppu_pkg;

  localparam int DATA_W_DEFAULT = 32;

  localparam logic [1:0] OCC_EMPTY = 2'b00;
  localparam logic [1:0] OCC_ONE   = 2'b01;
  localparam logic [1:0] OCC_TWO   = 2'b11;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nx1_pipe_skid.sv
// Generic 2-entry valid/ready skid buffer.
// Main register drives the output; skid absorbs one beat under stall.
module skid_buffer_2e
  import ppu_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0]       occ;
  logic [1:0]       occ_nx;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             emit;

  // Both flags come straight from occupancy flops.
  assign in_ready  = ~occ[1];
  assign out_valid = occ[0];
  assign out_data  = main_q;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_comb begin
    occ_nx = occ;
    unique case (occ)
      OCC_EMPTY: begin
        if (accept) occ_nx = OCC_ONE;
      end
      OCC_ONE: begin
        if (accept && !emit)
          occ_nx = OCC_TWO;
        else if (!accept && emit)
          occ_nx = OCC_EMPTY;
      end
      OCC_TWO: begin
        if (emit) occ_nx = OCC_ONE;
      end
      default: occ_nx = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ    <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      occ <= OCC_EMPTY;
    end else begin
      occ <= occ_nx;
      if (occ == OCC_TWO) begin
        if (emit) main_q <= skid_q;
      end else if (accept) begin
        if (occ == OCC_ONE && !emit)
          skid_q <= in_data;
        else
          main_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_pipe.sv
// N-input operand select feeding a 2-entry skid buffer.
// Out-of-range selects yield zero data tagged with selerr.
module mux_nx1_pipe
  import ppu_pkg::*;
#(
  parameter int WIDTH  = DATA_W_DEFAULT,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_selerr
);

  localparam int LANES = 1 << SEL_W;
  localparam logic [SEL_W:0] NUM_IN_C = (SEL_W + 1)'(NUM_IN);

  logic [LANES*WIDTH-1:0] padded;
  logic [WIDTH-1:0]       sel_data;
  logic                   sel_err;
  logic [WIDTH:0]         beat;

  // Pad to a power of two so every sel code indexes a real slice.
  always_comb begin
    padded = '0;
    padded[NUM_IN*WIDTH-1:0] = in_data;
  end

  assign sel_data = padded[int'(sel)*WIDTH +: WIDTH];
  assign sel_err  = ({1'b0, sel} >= NUM_IN_C);
  assign beat     = sel_err ? {1'b1, {WIDTH{1'b0}}}
                            : {1'b0, sel_data};

  skid_buffer_2e #(
    .WIDTH(WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_data  (beat),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data ({out_selerr, out_data}),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Scoreboard bench: 4x32 and 3x8 instances, directed then random traffic.
// Inputs are driven #1 after posedge; monitors sample on negedge.
module tb_mux_nx1_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic flush;

  logic [127:0] in_data4;
  logic [1:0]   sel4;
  logic         in_valid4, in_ready4;
  logic [31:0]  out_data4;
  logic         out_valid4, out_ready4, out_selerr4;

  logic [23:0]  in_data3;
  logic [1:0]   sel3;
  logic         in_valid3, in_ready3;
  logic [7:0]   out_data3;
  logic         out_valid3, out_ready3, out_selerr3;

  int tests = 0;
  int fails = 0;

  logic [32:0] q4[$];
  logic [8:0]  q3[$];

  mux_nx1_pipe #(.WIDTH(32), .NUM_IN(4)) u4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data4), .sel(sel4),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_selerr(out_selerr4)
  );

  mux_nx1_pipe #(.WIDTH(8), .NUM_IN(3)) u3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_selerr(out_selerr3)
  );

  // Reference: lane s of the packed bus, or {err, 0} past the last lane.
  function automatic logic [32:0] model4(logic [127:0] d, logic [1:0] s);
    logic [127:0] sh;
    sh = d >> (32 * int'(s));
    return {1'b0, sh[31:0]};
  endfunction

  function automatic logic [8:0] model3(logic [23:0] d, logic [1:0] s);
    logic [23:0] sh;
    if (int'(s) >= 3) return 9'h100;
    sh = d >> (8 * int'(s));
    return {1'b0, sh[7:0]};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard producers: record every accepted beat.
  always @(negedge clk) begin
    if (!reset && !flush && in_valid4 === 1'b1 && in_ready4 === 1'b1)
      q4.push_back(model4(in_data4, sel4));
    if (!reset && !flush && in_valid3 === 1'b1 && in_ready3 === 1'b1)
      q3.push_back(model3(in_data3, sel3));
  end

  logic        hold4 = 1'b0;
  logic [32:0] hdat4;
  logic        hold3 = 1'b0;
  logic [8:0]  hdat3;

  always @(negedge clk) begin
    logic [32:0] e4;
    if (hold4) begin
      tests++;
      if (out_valid4 !== 1'b1 || {out_selerr4, out_data4} !== hdat4) begin
        fails++;
        $display("FAIL hold4: got v=%b %0h expected %0h",
                 out_valid4, {out_selerr4, out_data4}, hdat4);
      end
    end
    if (out_valid4 === 1'b1 && out_ready4) begin
      tests++;
      if (q4.size() == 0) begin
        fails++;
        $display("FAIL emit4: got %0h expected no beat",
                 {out_selerr4, out_data4});
      end else begin
        e4 = q4.pop_front();
        if ({out_selerr4, out_data4} !== e4) begin
          fails++;
          $display("FAIL emit4: got %0h expected %0h",
                   {out_selerr4, out_data4}, e4);
        end
      end
    end
    if (reset || flush) q4.delete();
    hold4 = (out_valid4 === 1'b1) && !out_ready4 && !reset && !flush;
    hdat4 = {out_selerr4, out_data4};
  end

  always @(negedge clk) begin
    logic [8:0] e3;
    if (hold3) begin
      tests++;
      if (out_valid3 !== 1'b1 || {out_selerr3, out_data3} !== hdat3) begin
        fails++;
        $display("FAIL hold3: got v=%b %0h expected %0h",
                 out_valid3, {out_selerr3, out_data3}, hdat3);
      end
    end
    if (out_valid3 === 1'b1 && out_ready3) begin
      tests++;
      if (q3.size() == 0) begin
        fails++;
        $display("FAIL emit3: got %0h expected no beat",
                 {out_selerr3, out_data3});
      end else begin
        e3 = q3.pop_front();
        if ({out_selerr3, out_data3} !== e3) begin
          fails++;
          $display("FAIL emit3: got %0h expected %0h",
                   {out_selerr3, out_data3}, e3);
        end
      end
    end
    if (reset || flush) q3.delete();
    hold3 = (out_valid3 === 1'b1) && !out_ready3 && !reset && !flush;
    hdat3 = {out_selerr3, out_data3};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit keep4;
    bit keep3;
    reset = 1'b1;
    flush = 1'b0;
    in_data4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    sel4 = 2'd0;
    in_valid4 = 1'b1;
    out_ready4 = 1'b0;
    in_data3 = 24'h332211;
    sel3 = 2'd0;
    in_valid3 = 1'b1;
    out_ready3 = 1'b1;

    // Reset held two cycles with in_valid high
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", 64'(out_valid4), 64'd0);
      chk("rst_data", 64'(out_data4), 64'd0);
      chk("rst_selerr", 64'(out_selerr4), 64'd0);
      chk("rst_ready", 64'(in_ready4), 64'd1);
    end
    reset = 1'b0;
    in_valid4 = 1'b0;
    in_valid3 = 1'b0;
    tick();
    chk("post_rst_valid", 64'(out_valid4), 64'd0);
    chk("post_rst_ready", 64'(in_ready4), 64'd1);

    // Back-to-back stream, no bubbles
    out_ready4 = 1'b1;
    in_valid4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i);
      tick();
      chk("stream_valid", 64'(out_valid4), 64'd1);
      chk("stream_data", 64'(out_data4), 64'hA0 + 64'(i));
    end
    in_valid4 = 1'b0;
    tick();

    // Backpressure into the skid entry
    out_ready4 = 1'b0;
    in_valid4 = 1'b1;
    sel4 = 2'd0;
    in_data4 = 128'h11;
    tick();
    chk("bp_ready1", 64'(in_ready4), 64'd1);
    chk("bp_data1", 64'(out_data4), 64'h11);
    in_data4 = 128'h22;
    tick();
    chk("bp_ready2", 64'(in_ready4), 64'd0);
    chk("bp_hold", 64'(out_data4), 64'h11);
    in_valid4 = 1'b0;
    tick();
    chk("bp_stall", 64'(out_data4), 64'h11);
    out_ready4 = 1'b1;
    tick();
    chk("bp_second", 64'(out_data4), 64'h22);
    chk("bp_ready_back", 64'(in_ready4), 64'd1);
    tick();
    chk("bp_drained", 64'(out_valid4), 64'd0);

    // Out-of-range select on the 3-input instance
    in_valid3 = 1'b1;
    sel3 = 2'd3;
    tick();
    chk("bad_valid", 64'(out_valid3), 64'd1);
    chk("bad_data", 64'(out_data3), 64'd0);
    chk("bad_selerr", 64'(out_selerr3), 64'd1);
    sel3 = 2'd2;
    tick();
    chk("good_data", 64'(out_data3), 64'h33);
    chk("good_selerr", 64'(out_selerr3), 64'd0);
    in_valid3 = 1'b0;
    tick();

    // Flush from TWO with a beat offered
    out_ready4 = 1'b0;
    in_valid4 = 1'b1;
    in_data4 = 128'h44;
    tick();
    in_data4 = 128'h55;
    tick();
    chk("fl_two", 64'(in_ready4), 64'd0);
    flush = 1'b1;
    in_data4 = 128'h66;
    tick();
    chk("fl_valid", 64'(out_valid4), 64'd0);
    chk("fl_ready", 64'(in_ready4), 64'd1);
    chk("fl_data_hold", 64'(out_data4), 64'h44);
    // Flush outranks a same-cycle accept from ONE
    flush = 1'b0;
    in_data4 = 128'h77;
    tick();
    chk("fl1_valid", 64'(out_valid4), 64'd1);
    flush = 1'b1;
    in_data4 = 128'h88;
    tick();
    chk("fl1_cleared", 64'(out_valid4), 64'd0);
    flush = 1'b0;
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    tick();
    chk("fl1_dropped", 64'(out_valid4), 64'd0);

    // Reset while a beat is stalled
    out_ready4 = 1'b0;
    in_valid4 = 1'b1;
    in_data4 = 128'h99;
    tick();
    chk("mr_valid", 64'(out_valid4), 64'd1);
    reset = 1'b1;
    in_valid4 = 1'b0;
    tick();
    chk("mr_cleared", 64'(out_valid4), 64'd0);
    chk("mr_data", 64'(out_data4), 64'd0);
    chk("mr_selerr", 64'(out_selerr4), 64'd0);
    reset = 1'b0;
    tick();

    // Random traffic on both instances
    keep4 = 1'b0;
    keep3 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!keep4) begin
        in_valid4 = ($urandom_range(0, 3) != 0);
        in_data4 = {$urandom, $urandom, $urandom, $urandom};
        sel4 = 2'($urandom_range(0, 3));
      end
      if (!keep3) begin
        in_valid3 = ($urandom_range(0, 3) != 0);
        in_data3 = 24'($urandom);
        sel3 = 2'($urandom_range(0, 3));
      end
      out_ready4 = ($urandom_range(0, 2) != 0);
      out_ready3 = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      keep4 = in_valid4 && !in_ready4 && !flush;
      keep3 = in_valid3 && !in_ready3 && !flush;
      tick();
    end

    // Drain with a bounded wait
    in_valid4 = 1'b0;
    in_valid3 = 1'b0;
    flush = 1'b0;
    out_ready4 = 1'b1;
    out_ready3 = 1'b1;
    for (int i = 0; i < 10 && (q4.size() != 0 || q3.size() != 0); i++)
      tick();
    tick();
    chk("drain4", 64'(q4.size()), 64'd0);
    chk("drain3", 64'(q3.size()), 64'd0);
    chk("idle4", 64'(out_valid4), 64'd0);
    chk("idle3", 64'(out_valid3), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
